// File: rtl/fanout_broadcast_buf.sv
// Buffered broadcast stage: one valid/ready source fanned out to FANOUT leaves, each with its own DEPTH-entry FIFO.
// Optional source-stall counter enabled by defining FANOUT_BROADCAST_STALL_STATS_EN.
module fanout_broadcast_buf #(
  parameter int WIDTH  = 4,
  parameter int FANOUT = 8,
  parameter int DEPTH  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [FANOUT*WIDTH-1:0] out_data,
  output logic [FANOUT-1:0]       out_valid,
  input  logic [FANOUT-1:0]       out_ready,
  output logic                    busy,
  output logic [15:0]             stall_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [FANOUT-1:0] leaf_full;
  logic              push;

  // Ready depends only on registered counts, so a same-cycle pop on a full
  // leaf cannot bypass into the source handshake.
  assign in_ready = ~|leaf_full;
  assign push     = in_valid & in_ready;
  assign busy     = |out_valid;

  for (genvar g = 0; g < FANOUT; g++) begin : g_leaf
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             pop;

    assign pop = out_valid[g] & out_ready[g];

    always_comb begin
      // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      cnt_d = cnt_q + 1'b1;
      else if (pop && !push) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        // NOTE: storage is reset too, because out_data must read 0 straight out of reset.
        for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        // NOTE: sequential state uses non-blocking assignments so all leaves update from the same pre-edge values.
        rd_ptr_q <= rd_ptr_d;
        wr_ptr_q <= wr_ptr_d;
        cnt_q    <= cnt_d;
        if (push) mem_q[wr_ptr_q] <= in_data;
      end
    end

    assign leaf_full[g]                 = (cnt_q == FULL_CNT);
    assign out_valid[g]                 = (cnt_q != '0);
    assign out_data[g*WIDTH +: WIDTH]   = mem_q[rd_ptr_q];
  end

`ifdef FANOUT_BROADCAST_STALL_STATS_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (in_valid && !in_ready && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fanout_broadcast_buf.sv
// Self-checking bench for fanout_broadcast_buf: directed scenarios plus random traffic
// checked every cycle against a per-leaf queue model.
module tb_fanout_broadcast_buf;
  localparam int W = 4;
  localparam int F = 8;
  localparam int D = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   in_data;
  logic           in_valid;
  logic           in_ready;
  logic [F*W-1:0] out_data;
  logic [F-1:0]   out_valid;
  logic [F-1:0]   out_ready;
  logic           busy;
  logic [15:0]    stall_cnt;

  fanout_broadcast_buf #(.WIDTH(W), .FANOUT(F), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] mq [F][$];
  int unsigned  stall_exp;
  logic [W-1:0] got0[$];
  logic [W-1:0] got1[$];

  function automatic bit model_ready();
    for (int i = 0; i < F; i++) if (mq[i].size() >= D) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < F; i++) mq[i].delete();
    stall_exp = 0;
    got0.delete();
    got1.delete();
  endtask

  // Compare every observable output with the queue model, then advance one edge.
  task automatic step(output bit acc);
    logic [F-1:0] exp_valid;
    @(negedge clk);
    exp_valid = '0;
    for (int i = 0; i < F; i++) exp_valid[i] = (mq[i].size() != 0);
    checks++;
    if (in_ready !== model_ready()) begin
      failures++;
      $display("FAIL model_in_ready t=%0t got=%0b exp=%0b", $time, in_ready, model_ready());
    end
    checks++;
    if (out_valid !== exp_valid) begin
      failures++;
      $display("FAIL model_out_valid t=%0t got=%h exp=%h", $time, out_valid, exp_valid);
    end
    checks++;
    if (busy !== (exp_valid != '0)) begin
      failures++;
      $display("FAIL model_busy t=%0t got=%0b exp=%0b", $time, busy, exp_valid != '0);
    end
    for (int i = 0; i < F; i++) begin
      if (mq[i].size() != 0) begin
        checks++;
        if (out_data[i*W +: W] !== mq[i][0]) begin
          failures++;
          $display("FAIL model_out_data leaf=%0d t=%0t got=%h exp=%h", i, $time, out_data[i*W +: W], mq[i][0]);
        end
      end
    end
    checks++;
    if (stall_cnt !== 16'(stall_exp)) begin
      failures++;
      $display("FAIL model_stall_cnt t=%0t got=%0d exp=%0d", $time, stall_cnt, stall_exp);
    end
    if (out_valid[0] && out_ready[0]) got0.push_back(out_data[W-1:0]);
    if (out_valid[1] && out_ready[1]) got1.push_back(out_data[2*W-1:W]);

    acc = in_valid && model_ready();
`ifdef FANOUT_BROADCAST_STALL_STATS_EN
    if (in_valid && !model_ready() && stall_exp < 32'hFFFF) stall_exp++;
`endif
    begin
      logic [F-1:0] rdy;
      logic [W-1:0] d;
      rdy = out_ready;
      d   = in_data;
      @(posedge clk);
      for (int i = 0; i < F; i++) if (rdy[i] && mq[i].size() != 0) void'(mq[i].pop_front());
      if (acc) for (int i = 0; i < F; i++) mq[i].push_back(d);
    end
    #1;
  endtask

  task automatic tick(input int n);
    bit a;
    for (int k = 0; k < n; k++) step(a);
  endtask

  task automatic send(input logic [W-1:0] d);
    bit a;
    a = 1'b0;
    in_data  = d;
    in_valid = 1'b1;
    for (int n = 0; n < 50 && !a; n++) step(a);
    in_valid = 1'b0;
    checks++;
    if (!a) begin
      failures++;
      $display("FAIL send_timeout data=%h got=not_accepted exp=accepted", d);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = '1;
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = '1;
    model_clear();
    #12;
    checks++;
    if (out_valid !== '0) begin failures++; $display("FAIL reset_out_valid got=%h exp=00", out_valid); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++;
    if (out_data !== '0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    checks++;
    if (stall_cnt !== 16'h0) begin failures++; $display("FAIL reset_stall_cnt got=%h exp=0", stall_cnt); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    tick(3);
  endtask

  task automatic test_single_beat();
    bit a;
    do_reset();
    out_ready = 8'hFF;
    in_data   = 4'hA;
    in_valid  = 1'b1;
    step(a);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 8'hFF) begin failures++; $display("FAIL single_valid got=%h exp=ff", out_valid); end
    for (int i = 0; i < F; i++) begin
      checks++;
      if (out_data[i*W +: W] !== 4'hA) begin
        failures++;
        $display("FAIL single_data leaf=%0d got=%h exp=a", i, out_data[i*W +: W]);
      end
    end
    step(a);
    checks++;
    if (out_valid !== 8'h00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_drain got=valid %h busy %0b exp=valid 00 busy 0", out_valid, busy);
    end
  endtask

  task automatic test_full_hold();
    bit a;
    do_reset();
    out_ready = 8'h00;
    send(4'h1);
    send(4'h2);
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%0b exp=0", in_ready); end
    in_data  = 4'h3;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(a);
      checks++;
      if (a || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL full_third_taken got=acc %0b ready %0b exp=acc 0 ready 0", a, in_ready);
      end
    end
    out_ready = 8'hFF;
    send(4'h3);
    tick(4);
    checks++;
    if (got0.size() != 3 || got0[0] !== 4'h1 || got0[1] !== 4'h2 || got0[2] !== 4'h3) begin
      failures++;
      $display("FAIL full_order got=%p exp=1,2,3", got0);
    end
  endtask

  task automatic test_slow_leaf();
    bit a;
    do_reset();
    out_ready = 8'hFE;
    send(4'h5);
    send(4'h6);
    in_data  = 4'h7;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(a);
      checks++;
      if (a || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL slow_ready got=acc %0b ready %0b exp=acc 0 ready 0", a, in_ready);
      end
    end
    checks++;
    if (got1.size() != 2 || got1[0] !== 4'h5 || got1[1] !== 4'h6) begin
      failures++;
      $display("FAIL slow_leaf1 got=%p exp=5,6", got1);
    end
    out_ready = 8'hFF;
    send(4'h7);
    tick(4);
    checks++;
    if (got0.size() != 3 || got0[0] !== 4'h5 || got0[1] !== 4'h6 || got0[2] !== 4'h7) begin
      failures++;
      $display("FAIL slow_leaf0 got=%p exp=5,6,7", got0);
    end
    checks++;
    if (got1.size() != 3 || got1[2] !== 4'h7) begin
      failures++;
      $display("FAIL slow_leaf1_tail got=%p exp=5,6,7", got1);
    end
  endtask

  task automatic test_full_pop_and_reset();
    bit a;
    do_reset();
    out_ready = 8'h00;
    send(4'h8);
    send(4'h9);
    out_ready = 8'hFF;
    in_data   = 4'hB;
    in_valid  = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL pop_bypass got=%0b exp=0", in_ready); end
    step(a);
    checks++;
    if (a) begin failures++; $display("FAIL pop_same_cycle_acc got=1 exp=0"); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL pop_next_ready got=%0b exp=1", in_ready); end
    step(a);
    checks++;
    if (!a) begin failures++; $display("FAIL pop_accept got=0 exp=1"); end
    out_ready = 8'h00;
    in_data   = 4'hC;
    step(a);
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    checks++;
    if (out_valid !== '0 || busy !== 1'b0 || out_data !== '0) begin
      failures++;
      $display("FAIL midreset got=valid %h busy %0b data %h exp=0 0 0", out_valid, busy, out_data);
    end
    in_valid  = 1'b0;
    out_ready = 8'hFF;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    tick(3);
    checks++;
    if (got0.size() != 0) begin failures++; $display("FAIL midreset_discard got=%0d beats exp=0", got0.size()); end
  endtask

  task automatic test_stall_stats();
    do_reset();
    out_ready = 8'h00;
    send(4'h1);
    send(4'h2);
    in_data  = 4'h3;
    in_valid = 1'b1;
    tick(10);
`ifdef FANOUT_BROADCAST_STALL_STATS_EN
    checks++;
    if (stall_cnt !== 16'd10) begin failures++; $display("FAIL stall_10 got=%0d exp=10", stall_cnt); end
    tick(70000);
    checks++;
    if (stall_cnt !== 16'hFFFF) begin failures++; $display("FAIL stall_sat got=%h exp=ffff", stall_cnt); end
`else
    checks++;
    if (stall_cnt !== 16'h0000) begin failures++; $display("FAIL stall_off got=%h exp=0", stall_cnt); end
`endif
    in_valid = 1'b0;
  endtask

  task automatic test_random();
    bit a;
    do_reset();
    for (int k = 0; k < 600; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = W'($urandom);
      out_ready = F'($urandom) | F'($urandom);
      if ($urandom_range(0, 7) == 0) out_ready = '0;
      step(a);
    end
    in_valid  = 1'b0;
    out_ready = '1;
    tick(4);
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_full_hold();
    test_slow_leaf();
    test_full_pop_and_reset();
    test_stall_stats();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fanout_broadcast_buf.md
Name: fanout_broadcast_buf

Overview:
- Buffered broadcast stage that drives one high-fanout net into FANOUT independent leaf consumers.
- Sits directly upstream of a fanout-heavy block cluster. Each leaf gets its own small FIFO, so one slow consumer stalls the source but never corrupts the other leaves.
- Replaces a single heavily loaded net with FANOUT registered, locally driven nets.
- The source sees a single valid/ready port.

Parameters:
- WIDTH, 4, data width per beat.
- FANOUT, 8, number of leaf outputs; legal range 2..32.
- DEPTH, 2, entries per leaf FIFO; power of two, at least 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_data  input  WIDTH  source data.
- in_valid  input  1  source beat valid.
- in_ready  output  1  stage can accept a beat this cycle.
- out_data  output  FANOUT*WIDTH  leaf i data at bits [i*WIDTH +: WIDTH].
- out_valid  output  FANOUT  leaf i has a beat available.
- out_ready  input  FANOUT  leaf i consumes its head beat this cycle.
- busy  output  1  at least one leaf FIFO is non-empty.
- stall_cnt  output  16  source-stall cycle counter (see Optional Feature).

Behaviour:
- Reset (async assert, sync release):
  - all leaf FIFOs empty: count = 0, read and write pointers = 0;
  - out_valid = 0, out_data = 0, busy = 0, stall_cnt = 0;
  - in_ready = 1 from the first edge after release.
- Storage: one FIFO per leaf, each DEPTH x WIDTH, with a count register 0..DEPTH (width clog2(DEPTH)+1).
- in_ready = AND over all leaves of (count_i != DEPTH). Combinational from registered counts only; no path from out_ready or in_valid.
- Push:
  - when in_valid && in_ready, in_data is written into every leaf FIFO in the same cycle;
  - the write pointer wraps modulo DEPTH.
- Pop: leaf i pops when out_valid[i] && out_ready[i]; the read pointer wraps modulo DEPTH.
- Leaf outputs:
  - out_valid[i] = (count_i != 0);
  - out_data slice i = the entry at read pointer i; it holds its value while out_ready[i] = 0.
- Latency: a beat accepted on edge N is visible on all leaves after edge N, i.e. 1 cycle, with no combinational in-to-out path.
- Simultaneous push and pop on a leaf: count unchanged and both pointers advance.
- Full leaf:
  - a pop in the same cycle does not re-enable in_ready; there is no bypass;
  - the freed slot is visible to the source next cycle.
- Empty leaf: out_ready[i] while out_valid[i] = 0 is ignored, with no pointer or count change.
- Leaves drain independently; beat order per leaf equals source acceptance order.
- busy = OR over all leaves of (count_i != 0).
- in_valid while in_ready = 0: the beat is not taken and the source must hold it. Data stability is the source's responsibility and is not checked.
- Reset mid-transfer: all buffered beats are discarded and outputs return to reset values immediately on assertion.

Optional Feature:
- Macro: FANOUT_BROADCAST_STALL_STATS_EN.
- Defined:
  - stall_cnt increments by 1 on every cycle with in_valid && !in_ready;
  - it saturates at 16'hFFFF and never wraps;
  - it is cleared only by rst.
- Undefined: stall_cnt is tied to 16'h0000 and the counter logic is not present.

Test Plan:
- Reset, then idle with out_ready all 1:
  - in_ready = 1, out_valid = 8'h00, busy = 0, out_data = 0.
- Single beat in_data = 4'hA, out_ready = 8'hFF:
  - next cycle out_valid = 8'hFF and every slice = 4'hA;
  - following cycle out_valid = 8'h00, busy = 0.
- out_ready = 8'h00, push 4'h1 then 4'h2 (DEPTH = 2):
  - in_ready drops to 0 after the 2nd accept;
  - a 3rd beat 4'h3 with in_valid held is not taken;
  - set out_ready = 8'hFF: leaves emit 1, 2, then 3, in order.
- Slow leaf: out_ready = 8'hFE, stream 4'h5, 4'h6, 4'h7:
  - leaves 1..7 receive 5, 6;
  - in_ready is 0 while leaf 0 holds 2 beats;
  - releasing out_ready[0] lets leaf 0 deliver 5, 6, then 7 with no loss or duplication.
- Full leaf with a same-cycle pop:
  - in_ready stays 0 that cycle and rises next cycle;
  - assert rst mid-stream: out_valid = 0 immediately, and all beats are discarded after release.
- With FANOUT_BROADCAST_STALL_STATS_EN:
  - hold in_valid with all leaves full for 10 cycles: stall_cnt = 10;
  - force 70000 stall cycles: stall_cnt = 16'hFFFF;
  - without the macro, stall_cnt = 0 throughout.
